// File: rtl/unidade_controle_exp6_if.sv
// Control/status bundle between the game controller and its datapath.
// The datapath side (master) drives the status flags and consumes the control strobes.
interface unidade_controle_exp6_if;
    logic       iniciar;
    logic       fimE;
    logic       fimRod;
    logic       fimT;
    logic       igual;
    logic       enderecoIgualRodada;
    logic       jogada_feita;

    logic       zeraE;
    logic       contaE;
    logic       zeraRod;
    logic       contaRod;
    logic       zeraT;
    logic       contaT;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [4:0] db_estado;

    modport master (
        output iniciar, fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita,
        input  zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR,
        input  pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        input  iniciar, fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita,
        output zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR,
        output pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_exp6.sv
// Moore controller for the memory game: sequences rounds and plays, and reports
// the game outcome (hit, miss or timeout).
module unidade_controle_exp6 #(
    parameter bit TIMEOUT_HAB = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    unidade_controle_exp6_if.slave   ctl
);

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        PREPARACAO     = 5'h01,
        INICIA_RODADA  = 5'h02,
        ESPERA_JOGADA  = 5'h03,
        REGISTRA       = 5'h04,
        COMPARA        = 5'h05,
        PROXIMA_JOGADA = 5'h06,
        PROXIMA_RODADA = 5'h07,
        FINAL_ACERTOU  = 5'h0A,
        FINAL_ERROU    = 5'h0E,
        FINAL_TIMEOUT  = 5'h0F
    } estado_t;

    // Output vector order: zeraE contaE zeraRod contaRod zeraT contaT zeraR registraR
    //                      pronto acertou errou timeout
    localparam logic [11:0] S_NADA      = 12'b0000_0000_0000;
    localparam logic [11:0] S_PREPARA   = 12'b1010_1010_0000;
    localparam logic [11:0] S_INICIA    = 12'b1000_1000_0000;
    localparam logic [11:0] S_ESPERA    = 12'b0000_0100_0000;
    localparam logic [11:0] S_REGISTRA  = 12'b0000_1001_0000;
    localparam logic [11:0] S_PROX_JOG  = 12'b0100_0000_0000;
    localparam logic [11:0] S_PROX_ROD  = 12'b0001_0000_0000;
    localparam logic [11:0] S_ACERTOU   = 12'b0000_0000_1100;
    localparam logic [11:0] S_ERROU     = 12'b0000_0000_1010;
    localparam logic [11:0] S_TIMEOUT   = 12'b0000_0000_1001;

    estado_t     estado_r;
    estado_t     prox_s;
    logic [11:0] saidas_r;
    logic        unused_s;

    // Next-state rule; a play in the same cycle as timer end takes priority.
    function automatic estado_t proximo(
        input estado_t e,
        input logic    ini,
        input logic    jf,
        input logic    ft,
        input logic    ig,
        input logic    eir,
        input logic    fr
    );
        estado_t n;
        case (e)
            INICIAL:        n = ini ? PREPARACAO : INICIAL;
            PREPARACAO:     n = INICIA_RODADA;
            INICIA_RODADA:  n = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jf) begin
                    n = REGISTRA;
                end else if (ft && TIMEOUT_HAB) begin
                    n = FINAL_TIMEOUT;
                end else begin
                    n = ESPERA_JOGADA;
                end
            end
            REGISTRA:       n = COMPARA;
            COMPARA: begin
                if (!ig) begin
                    n = FINAL_ERROU;
                end else if (!eir) begin
                    n = PROXIMA_JOGADA;
                end else if (!fr) begin
                    n = PROXIMA_RODADA;
                end else begin
                    n = FINAL_ACERTOU;
                end
            end
            PROXIMA_JOGADA: n = ESPERA_JOGADA;
            PROXIMA_RODADA: n = INICIA_RODADA;
            FINAL_ACERTOU:  n = ini ? PREPARACAO : FINAL_ACERTOU;
            FINAL_ERROU:    n = ini ? PREPARACAO : FINAL_ERROU;
            FINAL_TIMEOUT:  n = ini ? PREPARACAO : FINAL_TIMEOUT;
            default:        n = INICIAL;
        endcase
        return n;
    endfunction

    // Moore decode of a state code into the control/status vector.
    function automatic logic [11:0] decodifica(input estado_t e);
        logic [11:0] s;
        case (e)
            PREPARACAO:     s = S_PREPARA;
            INICIA_RODADA:  s = S_INICIA;
            ESPERA_JOGADA:  s = S_ESPERA;
            REGISTRA:       s = S_REGISTRA;
            PROXIMA_JOGADA: s = S_PROX_JOG;
            PROXIMA_RODADA: s = S_PROX_ROD;
            FINAL_ACERTOU:  s = S_ACERTOU;
            FINAL_ERROU:    s = S_ERROU;
            FINAL_TIMEOUT:  s = S_TIMEOUT;
            default:        s = S_NADA;
        endcase
        return s;
    endfunction

    // Next state from the current state and the datapath flags.
    always_comb begin
        prox_s = proximo(estado_r, ctl.iniciar, ctl.jogada_feita, ctl.fimT,
                         ctl.igual, ctl.enderecoIgualRodada, ctl.fimRod);
    end

    // State register; outputs are registered as the decode of the state being entered,
    // so they always equal the decode of estado_r.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r <= INICIAL;
            saidas_r <= S_NADA;
        end else begin
            estado_r <= prox_s;
            saidas_r <= decodifica(prox_s);
        end
    end

    // fimE is informational only; round end is decided by enderecoIgualRodada.
    assign unused_s = ctl.fimE;

    assign ctl.zeraE     = saidas_r[11];
    assign ctl.contaE    = saidas_r[10];
    assign ctl.zeraRod   = saidas_r[9];
    assign ctl.contaRod  = saidas_r[8];
    assign ctl.zeraT     = saidas_r[7];
    assign ctl.contaT    = saidas_r[6];
    assign ctl.zeraR     = saidas_r[5];
    assign ctl.registraR = saidas_r[4];
    assign ctl.pronto    = saidas_r[3];
    assign ctl.acertou   = saidas_r[2];
    assign ctl.errou     = saidas_r[1];
    assign ctl.timeout   = saidas_r[0];
    assign ctl.db_estado = estado_r;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// Bench for unidade_controle_exp6: directed game scenarios plus random play, both
// timeout settings, checked every cycle against a game-level reference model.
module tb_unidade_controle_exp6;

    logic clock;
    logic reset;
    logic iniciar, fimE, fimRod, fimT, igual, eir, jogada_feita;

    unidade_controle_exp6_if ifc1();
    unidade_controle_exp6_if ifc2();

    unidade_controle_exp6 #(.TIMEOUT_HAB(1'b1)) u_dut (
        .clock (clock),
        .reset (reset),
        .ctl   (ifc1)
    );

    unidade_controle_exp6 #(.TIMEOUT_HAB(1'b0)) u_dut_nt (
        .clock (clock),
        .reset (reset),
        .ctl   (ifc2)
    );

    assign ifc1.iniciar = iniciar;             assign ifc2.iniciar = iniciar;
    assign ifc1.fimE = fimE;                   assign ifc2.fimE = fimE;
    assign ifc1.fimRod = fimRod;               assign ifc2.fimRod = fimRod;
    assign ifc1.fimT = fimT;                   assign ifc2.fimT = fimT;
    assign ifc1.igual = igual;                 assign ifc2.igual = igual;
    assign ifc1.enderecoIgualRodada = eir;     assign ifc2.enderecoIgualRodada = eir;
    assign ifc1.jogada_feita = jogada_feita;   assign ifc2.jogada_feita = jogada_feita;

    logic [11:0] out1, out2;
    assign out1 = {ifc1.zeraE, ifc1.contaE, ifc1.zeraRod, ifc1.contaRod, ifc1.zeraT, ifc1.contaT,
                   ifc1.zeraR, ifc1.registraR, ifc1.pronto, ifc1.acertou, ifc1.errou, ifc1.timeout};
    assign out2 = {ifc2.zeraE, ifc2.contaE, ifc2.zeraRod, ifc2.contaRod, ifc2.zeraT, ifc2.contaT,
                   ifc2.zeraR, ifc2.registraR, ifc2.pronto, ifc2.acertou, ifc2.errou, ifc2.timeout};

    int          num_checks = 0;
    int          num_errors = 0;
    int          m1, m2;          // expected state codes (timeout enabled / disabled)
    int          addr, rnd;       // datapath counters as the game would see them
    int          n_conta_e, n_conta_rod;
    logic [11:0] exp_out [0:31];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game rules as stated for the controller, one step per clock.
    function automatic int ref_prox(int s, bit hab, bit ini, bit jf, bit ft, bit ig, bit ei, bit fr);
        if (s == 0 || s == 'h0A || s == 'h0E || s == 'h0F) return ini ? 1 : s;
        if (s == 1) return 2;
        if (s == 2) return 3;
        if (s == 3) return jf ? 4 : ((ft && hab) ? 'h0F : 3);
        if (s == 4) return 5;
        if (s == 5) return !ig ? 'h0E : (!ei ? 6 : (fr ? 'h0A : 7));
        if (s == 6) return 3;
        if (s == 7) return 2;
        return 0;
    endfunction

    task automatic ciclo();
        int n1, n2;
        logic [11:0] e;
        eir    = (addr == rnd);
        fimRod = (rnd == 15);
        fimE   = (addr == 15);
        n1 = reset ? ref_prox(m1, 1'b1, iniciar, jogada_feita, fimT, igual, eir, fimRod) : 0;
        n2 = reset ? ref_prox(m2, 1'b0, iniciar, jogada_feita, fimT, igual, eir, fimRod) : 0;
        @(posedge clock);
        e = exp_out[m1];
        if (e[11]) addr = 0;
        if (e[10]) addr = addr + 1;
        if (e[9])  rnd = 0;
        if (e[8])  rnd = rnd + 1;
        m1 = n1;
        m2 = n2;
        @(negedge clock);
        if (out1[10]) n_conta_e++;
        if (out1[8])  n_conta_rod++;
        check("estado_hab", {27'd0, ifc1.db_estado}, m1);
        check("saidas_hab", {20'd0, out1}, {20'd0, exp_out[m1]});
        check("estado_nohab", {27'd0, ifc2.db_estado}, m2);
        check("saidas_nohab", {20'd0, out2}, {20'd0, exp_out[m2]});
    endtask

    // Reset dropped mid-cycle (called at a falling edge), released one cycle later.
    task automatic pulso_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_estado_hab", {27'd0, ifc1.db_estado}, 32'd0);
        check("rst_saidas_hab", {20'd0, out1}, 32'd0);
        check("rst_estado_nohab", {27'd0, ifc2.db_estado}, 32'd0);
        check("rst_saidas_nohab", {20'd0, out2}, 32'd0);
        m1 = 0;
        m2 = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_out[i] = 12'h000;
        exp_out[1]    = 12'b1010_1010_0000;
        exp_out[2]    = 12'b1000_1000_0000;
        exp_out[3]    = 12'b0000_0100_0000;
        exp_out[4]    = 12'b0000_1001_0000;
        exp_out[6]    = 12'b0100_0000_0000;
        exp_out[7]    = 12'b0001_0000_0000;
        exp_out['h0A] = 12'b0000_0000_1100;
        exp_out['h0E] = 12'b0000_0000_1010;
        exp_out['h0F] = 12'b0000_0000_1001;

        reset = 1'b0; iniciar = 1'b0; fimE = 1'b0; fimRod = 1'b0; fimT = 1'b0;
        igual = 1'b0; eir = 1'b0; jogada_feita = 1'b0;
        m1 = 0; m2 = 0; addr = 0; rnd = 0; n_conta_e = 0; n_conta_rod = 0;
        repeat (2) @(negedge clock);
        check("reset_estado", {27'd0, ifc1.db_estado}, 32'd0);
        check("reset_saidas", {20'd0, out1}, 32'd0);
        reset = 1'b1;
        ciclo();
        check("espera_iniciar", {27'd0, ifc1.db_estado}, 32'd0);

        // Start: 01h, 02h, 03h
        iniciar = 1'b1; ciclo(); iniciar = 1'b0;
        ciclo(); ciclo();
        // Round 0 correct, not last: 04h, 05h, 07h, 02h, 03h
        igual = 1'b1; jogada_feita = 1'b1; ciclo(); jogada_feita = 1'b0;
        ciclo(); ciclo();
        check("conta_rod_r0", {31'd0, ifc1.contaRod}, 32'd1);
        ciclo(); ciclo();
        // Wrong play: 04h, 05h, 0Eh held, then restart
        igual = 1'b0; jogada_feita = 1'b1; ciclo(); jogada_feita = 1'b0;
        ciclo(); ciclo();
        repeat (10) ciclo();
        check("errou_mantido", {30'd0, ifc1.pronto, ifc1.errou}, 32'd3);
        iniciar = 1'b1; ciclo(); iniciar = 1'b0;
        check("reinicio", {27'd0, ifc1.db_estado}, 32'd1);
        ciclo(); ciclo();
        // Timer end: enabled -> 0Fh, disabled -> stays 03h counting
        fimT = 1'b1; ciclo(); fimT = 1'b0;
        check("timeout_hab", {31'd0, ifc1.timeout}, 32'd1);
        check("timeout_nohab", {31'd0, ifc2.contaT}, 32'd1);
        iniciar = 1'b1; ciclo(); iniciar = 1'b0;
        ciclo(); ciclo();
        // Play and timer end together: play wins
        igual = 1'b1; fimT = 1'b1; jogada_feita = 1'b1; ciclo();
        fimT = 1'b0; jogada_feita = 1'b0;
        check("jogada_vence", {27'd0, ifc1.db_estado}, 32'd4);

        // Full 16-round game, all plays correct
        pulso_reset();
        n_conta_e = 0; n_conta_rod = 0;
        iniciar = 1'b1; ciclo(); iniciar = 1'b0;
        igual = 1'b1;
        for (int k = 0; k < 1500 && m1 != 'h0A; k++) begin
            jogada_feita = (m1 == 3);
            ciclo();
        end
        jogada_feita = 1'b0;
        check("jogo_completo", {27'd0, ifc1.db_estado}, 32'h0A);
        check("acertou", {30'd0, ifc1.pronto, ifc1.acertou}, 32'd3);
        check("total_conta_rod", n_conta_rod, 32'd15);
        check("total_conta_e", n_conta_e, 32'd120);

        // Asynchronous reset while in compara
        iniciar = 1'b1; ciclo(); iniciar = 1'b0;
        for (int k = 0; k < 50 && m1 != 5; k++) begin
            jogada_feita = (m1 == 3);
            ciclo();
        end
        jogada_feita = 1'b0;
        check("em_compara", {27'd0, ifc1.db_estado}, 32'd5);
        pulso_reset();

        // Random play
        for (int k = 0; k < 4000; k++) begin
            iniciar      = ($urandom_range(0, 7) == 0);
            jogada_feita = ($urandom_range(0, 3) == 0);
            fimT         = ($urandom_range(0, 11) == 0);
            igual        = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 399) == 0) pulso_reset();
            ciclo();
        end

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_exp6.md
UNIDADE_CONTROLE_EXP6 -- requirements
Module: unidade_controle_exp6

Interface
REQ-001 Parameter: TIMEOUT_HAB, default 1, meaning 1 = fimT aborts the game, 0 = fimT ignored.
REQ-002 Port: clock  in  1  rising-edge system clock, the single clock of the block.
REQ-003 Port: reset  in  1  asynchronous, active-low; low forces state inicial immediately.
REQ-004 Port: iniciar  in  1  start/restart request, level-sampled.
REQ-005 Port: fimE, fimRod, fimT  in  1 each  address-counter RCO, round-counter RCO, timer end.
REQ-006 Port: igual, enderecoIgualRodada  in  1 each  play matches memory; address equals round.
REQ-007 Port: jogada_feita  in  1  one-cycle pulse from the datapath edge detector.
REQ-008 Port: zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR  out  1 each  datapath controls.
REQ-009 Port: pronto, acertou, errou, timeout  out  1 each  game-end status.
REQ-010 Port: db_estado  out  5  current state code, for display.

Function
REQ-011 Moore FSM; every output SHALL be a combinational decode of the state register only.
REQ-012 State codes SHALL be: inicial 00h, preparacao 01h, inicia_rodada 02h, espera_jogada 03h, registra 04h, compara 05h, proxima_jogada 06h, proxima_rodada 07h, final_acertou 0Ah, final_errou 0Eh, final_timeout 0Fh.
REQ-013 inicial: all outputs 0; iniciar=1 -> preparacao, else stay.
REQ-014 preparacao: zeraE=zeraRod=zeraR=zeraT=1; -> inicia_rodada unconditionally.
REQ-015 inicia_rodada: zeraE=zeraT=1; -> espera_jogada.
REQ-016 espera_jogada: contaT=1; jogada_feita=1 -> registra; else fimT=1 and TIMEOUT_HAB=1 -> final_timeout; else stay.
REQ-017 jogada_feita and fimT in the same cycle: the play SHALL win (-> registra).
REQ-018 registra: registraR=1, zeraT=1; -> compara (compare one cycle after the register load).
REQ-019 compara: igual=0 -> final_errou; igual=1 and enderecoIgualRodada=0 -> proxima_jogada; igual=1, enderecoIgualRodada=1, fimRod=0 -> proxima_rodada; igual=1, enderecoIgualRodada=1, fimRod=1 -> final_acertou.
REQ-020 proxima_jogada: contaE=1; -> espera_jogada.
REQ-021 proxima_rodada: contaRod=1; -> inicia_rodada (address restarts at 0 for the new round).
REQ-022 Final states: pronto=1 plus exactly one of acertou/errou/timeout=1, held while in state; iniciar=1 -> preparacao, else stay.
REQ-023 fimE SHALL NOT affect transitions (debug only); enderecoIgualRodada governs round end.
REQ-024 Unused 5-bit codes SHALL transition to inicial with all outputs 0.
REQ-025 iniciar SHALL be ignored in all states other than inicial and the three final states.
REQ-026 At most one count strobe (contaE, contaRod, contaT) SHALL be high in any cycle.

Reset
REQ-027 reset=0 SHALL asynchronously force inicial; all outputs 0, db_estado=00h, regardless of clock.
REQ-028 Reset asserted mid-game (any state) SHALL abandon the game; after release the block waits for iniciar.
REQ-029 First state change after reset release SHALL occur no earlier than the first rising clock edge with reset=1.

Verification
REQ-030 reset pulse, iniciar=1 one cycle -> db_estado sequence 00h,01h,02h,03h; zeraE/zeraRod/zeraR/zeraT high in 01h.
REQ-031 Round 0: in 03h pulse jogada_feita, igual=1, enderecoIgualRodada=1, fimRod=0 -> 04h,05h,07h (contaRod=1 one cycle),02h,03h.
REQ-032 In 03h pulse jogada_feita with igual=0 -> 04h,05h,0Eh; errou=1, pronto=1 held 10 cycles; iniciar=1 -> 01h.
REQ-033 In 03h raise fimT, TIMEOUT_HAB=1 -> 0Fh, timeout=1; repeat with TIMEOUT_HAB=0 -> stays 03h, contaT=1; repeat with fimT and jogada_feita together -> 04h.
REQ-034 Full game: 16 rounds all correct, fimRod=1 in last compara -> 0Ah, acertou=1; total contaRod pulses = 15, contaE pulses = 120.
REQ-035 Assert reset low mid-cycle while in 05h -> db_estado=00h before the next clock edge; all outputs 0.
